// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
// Shared types and helpers for the parallel-in/serial-out transmitter.
//   state_t    : transmitter FSM state encoding (IDLE, SHIFT, GAP)
//   calc_cnt_w : width of the shared bit/gap counter, sized so the counter can
//                hold max(WIDTH, GAP_CYCLES) without wrapping inside a frame
// -----------------------------------------------------------------------------
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int calc_cnt_w(input int width, input int gap_cycles);
    int max_val;
    max_val = (width > gap_cycles) ? width : gap_cycles;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Up-counter shared by the SHIFT and GAP phases of the transmitter.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears the count
//   clr     : synchronous clear (wins over en)
//   en      : count enable
//   limit   : runtime terminal value for the current phase
//   count   : current count
//   last    : count equals limit
// -----------------------------------------------------------------------------
module piso_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == limit);

endmodule

// File: rtl/piso_tx_asyn_rstn.sv
// -----------------------------------------------------------------------------
// piso_tx_asyn_rstn
// Parallel-in/serial-out transmitter. Accepts one WIDTH-bit word per
// handshake in IDLE, shifts it out one bit per clock in SHIFT with framing
// strobes, then idles for GAP_CYCLES cycles in GAP before accepting again.
// Ports:
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   load_valid  : producer offers load_data
//   load_data   : word to transmit (sampled only at the accept edge)
//   load_ready  : high only in IDLE
//   sdo / sdo_n : serial data and its complement (line idles low)
//   sdo_valid   : sdo carries a frame bit
//   frame_start : first bit of the frame is on sdo
//   frame_end   : last bit of the frame is on sdo
//   busy        : FSM is not in IDLE
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module piso_tx_asyn_rstn
  import piso_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_n,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = calc_cnt_w(WIDTH, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SHIFT_LIMIT = CNT_W'(WIDTH - 1);
  // With no gap the GAP state is unreachable; the limit value is irrelevant.
  localparam logic [CNT_W-1:0] GAP_LIMIT =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_last;

  // Move every bit one position toward the head; the vacated tail fills with 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST != 0) begin : g_lsb
        if (gi == WIDTH - 1) begin : g_tail
          assign shifted[gi] = 1'b0;
        end else begin : g_body
          assign shifted[gi] = shift_reg[gi+1];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_tail
          assign shifted[gi] = 1'b0;
        end else begin : g_body
          assign shifted[gi] = shift_reg[gi-1];
        end
      end
    end
  endgenerate

  assign head_bit = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[WIDTH-1];

  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .limit   (cnt_limit),
    .count   (cnt_value),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_limit  = (state_reg == GAP) ? GAP_LIMIT : SHIFT_LIMIT;
    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          shift_next = load_data;
          cnt_clr    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_next = shifted;
        if (cnt_last) begin
          // Counter reloads to 0 so the GAP phase reuses it.
          cnt_clr    = 1'b1;
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      GAP: begin
        if (cnt_last) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  logic in_shift;
  assign in_shift    = (state_reg == SHIFT);
  assign sdo         = in_shift & head_bit;
  assign sdo_n       = ~sdo;
  assign sdo_valid   = in_shift;
  assign frame_start = in_shift & (cnt_value == '0);
  assign frame_end   = in_shift & cnt_last;
  assign busy        = (state_reg != IDLE);
  assign load_ready  = (state_reg == IDLE);

endmodule
